// File: rtl/btb_assoc_pkg.sv
// Shared definitions for the set-associative branch target buffer.
// Holds the 2-bit direction counter encoding and the saturating counter step.
package btb_assoc_pkg;

    localparam int BTB_CTR_W = 2;

    typedef enum logic [BTB_CTR_W-1:0] {
        BTB_CTR_SNT = 2'b00,
        BTB_CTR_WNT = 2'b01,
        BTB_CTR_WT  = 2'b10,
        BTB_CTR_ST  = 2'b11
    } btb_ctr_e;

    // Saturating step: strongly-taken and strongly-not-taken are sticky.
    function automatic logic [BTB_CTR_W-1:0] btb_ctr_next(
        input logic [BTB_CTR_W-1:0] ctr,
        input logic                 taken
    );
        logic [BTB_CTR_W-1:0] r;
        r = ctr;
        if (taken) begin
            if (ctr != BTB_CTR_ST) r = ctr + 2'd1;
        end else begin
            if (ctr != BTB_CTR_SNT) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_assoc_way.sv
// One way of the BTB: SETS-deep storage of {valid, is_jump, tag, target, ctr}.
// Ports:
//   clk, rst            clock, async active-high reset (clears valid and ctr)
//   flush_i             clear every valid bit on the next edge
//   rd_idx_i / rd_*_o   combinational lookup read port
//   up_idx_i / up_*_o   combinational read at the update index (hit detect, ctr)
//   we_i, wr_*_i        write of a full entry at up_idx_i, marks it valid
module btb_assoc_way
    import btb_assoc_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int TAG_WIDTH  = 20,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_jump_o,
    output logic [TAG_WIDTH-1:0]  rd_tag_o,
    output logic [ADDR_WIDTH-1:0] rd_target_o,
    output logic [BTB_CTR_W-1:0]  rd_ctr_o,
    input  logic [IDX_W-1:0]      up_idx_i,
    output logic                  up_valid_o,
    output logic [TAG_WIDTH-1:0]  up_tag_o,
    output logic [BTB_CTR_W-1:0]  up_ctr_o,
    input  logic                  we_i,
    input  logic                  wr_jump_i,
    input  logic [TAG_WIDTH-1:0]  wr_tag_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i,
    input  logic [BTB_CTR_W-1:0]  wr_ctr_i
);

    logic [SETS-1:0]       valid_q;
    logic [BTB_CTR_W-1:0]  ctr_q    [SETS];
    logic                  jump_q   [SETS];
    logic [TAG_WIDTH-1:0]  tag_q    [SETS];
    logic [ADDR_WIDTH-1:0] target_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) ctr_q[s] <= BTB_CTR_SNT;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (we_i) begin
                valid_q[up_idx_i] <= 1'b1;
            end
            // Flush leaves counters alone; only valid bits are cleared.
            if (we_i && !flush_i) ctr_q[up_idx_i] <= wr_ctr_i;
        end
    end

    // Payload needs no reset: it is never observed while its valid bit is 0.
    always_ff @(posedge clk) begin
        if (we_i && !flush_i) begin
            jump_q[up_idx_i]   <= wr_jump_i;
            tag_q[up_idx_i]    <= wr_tag_i;
            target_q[up_idx_i] <= wr_target_i;
        end
    end

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_jump_o   = jump_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];
    assign up_valid_o  = valid_q[up_idx_i];
    assign up_tag_o    = tag_q[up_idx_i];
    assign up_ctr_o    = ctr_q[up_idx_i];

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer for the fetch stage.
// Lookup is combinational on pc_in; updates from ID are written on the rising edge.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pc_in                         fetch PC to look up
//   is_branch_out/is_jump_out     hit / hit entry is an unconditional jump
//   pred_taken_out/target_out     predicted direction and target (0 on miss)
//   upd_*_in                      resolved branch report from ID
//   flush_in                      invalidate the whole table
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  is_branch_out,
    output logic                  is_jump_out,
    output logic                  pred_taken_out,
    output logic [ADDR_WIDTH-1:0] target_out,
    input  logic                  upd_valid_in,
    input  logic [ADDR_WIDTH-1:0] upd_pc_in,
    input  logic                  upd_is_jump_in,
    input  logic                  upd_taken_in,
    input  logic [ADDR_WIDTH-1:0] upd_target_in,
    input  logic                  flush_in
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [IDX_W-1:0]     lk_idx, up_idx;
    logic [TAG_WIDTH-1:0] lk_tag, up_tag;

    assign lk_idx = pc_in[2 +: IDX_W];
    assign lk_tag = pc_in[2+IDX_W +: TAG_WIDTH];
    assign up_idx = upd_pc_in[2 +: IDX_W];
    assign up_tag = upd_pc_in[2+IDX_W +: TAG_WIDTH];

    // pc[1:0] and bits above the tag take no part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_in, upd_pc_in};

    logic [WAYS-1:0]       lk_valid, lk_jump, up_valid, we_way;
    logic [TAG_WIDTH-1:0]  lk_tag_w [WAYS];
    logic [TAG_WIDTH-1:0]  up_tag_w [WAYS];
    logic [ADDR_WIDTH-1:0] lk_tgt_w [WAYS];
    logic [BTB_CTR_W-1:0]  lk_ctr_w [WAYS];
    logic [BTB_CTR_W-1:0]  up_ctr_w [WAYS];
    logic [BTB_CTR_W-1:0]  wr_ctr;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_assoc_way #(
            .SETS(SETS), .TAG_WIDTH(TAG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_in),
            .rd_idx_i    (lk_idx),
            .rd_valid_o  (lk_valid[w]),
            .rd_jump_o   (lk_jump[w]),
            .rd_tag_o    (lk_tag_w[w]),
            .rd_target_o (lk_tgt_w[w]),
            .rd_ctr_o    (lk_ctr_w[w]),
            .up_idx_i    (up_idx),
            .up_valid_o  (up_valid[w]),
            .up_tag_o    (up_tag_w[w]),
            .up_ctr_o    (up_ctr_w[w]),
            .we_i        (we_way[w]),
            .wr_jump_i   (upd_is_jump_in),
            .wr_tag_i    (up_tag),
            .wr_target_i (upd_target_in),
            .wr_ctr_i    (wr_ctr)
        );
    end

    // Lookup: descending scan so the lowest matching way wins.
    always_comb begin
        is_branch_out  = 1'b0;
        is_jump_out    = 1'b0;
        pred_taken_out = 1'b0;
        target_out     = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (lk_valid[w] && (lk_tag_w[w] == lk_tag)) begin
                is_branch_out  = 1'b1;
                is_jump_out    = lk_jump[w];
                pred_taken_out = lk_jump[w] | lk_ctr_w[w][1];
                target_out     = lk_tgt_w[w];
            end
        end
    end

    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] hit_way, inv_way, sel_way;
    logic             up_hit, inv_found, we_any, ptr_adv, taken_eff;

    always_comb begin
        up_hit    = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (up_valid[w] && (up_tag_w[w] == up_tag)) begin
                up_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!up_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end

        taken_eff = upd_taken_in | upd_is_jump_in;
        we_any    = 1'b0;
        ptr_adv   = 1'b0;
        sel_way   = '0;
        wr_ctr    = BTB_CTR_SNT;
        if (upd_valid_in && !flush_in) begin
            if (up_hit) begin
                we_any  = 1'b1;
                sel_way = hit_way;
                wr_ctr  = btb_ctr_next(up_ctr_w[hit_way], taken_eff);
            end else if (taken_eff) begin
                we_any = 1'b1;
                wr_ctr = upd_is_jump_in ? BTB_CTR_ST : BTB_CTR_WT;
                if (inv_found) begin
                    sel_way = inv_way;
                end else begin
                    sel_way = ptr_q[up_idx];
                    ptr_adv = 1'b1;
                end
            end
        end

        we_way = '0;
        if (we_any) we_way[sel_way] = 1'b1;
    end

    // Victim pointer only moves when a full set had to give up an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (flush_in) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (ptr_adv) begin
            ptr_q[up_idx] <= (ptr_q[up_idx] == WAY_W'(WAYS-1)) ? '0 : ptr_q[up_idx] + WAY_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;

    localparam int AW    = 32;
    localparam int SETS  = 64;
    localparam int WAYS  = 4;
    localparam int TW    = 20;
    localparam int IDX_W = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          is_branch_out, is_jump_out, pred_taken_out;
    logic [AW-1:0] target_out;
    logic          upd_valid_in, upd_is_jump_in, upd_taken_in, flush_in;
    logic [AW-1:0] upd_pc_in, upd_target_in;

    always #5 clk = ~clk;

    btb_assoc #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .is_branch_out  (is_branch_out),
        .is_jump_out    (is_jump_out),
        .pred_taken_out (pred_taken_out),
        .target_out     (target_out),
        .upd_valid_in   (upd_valid_in),
        .upd_pc_in      (upd_pc_in),
        .upd_is_jump_in (upd_is_jump_in),
        .upd_taken_in   (upd_taken_in),
        .upd_target_in  (upd_target_in),
        .flush_in       (flush_in)
    );

    typedef struct packed {
        logic          hit;
        logic          jump;
        logic          pred;
        logic [AW-1:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of the table.
    bit            m_valid [SETS][WAYS];
    bit            m_jump  [SETS][WAYS];
    logic [TW-1:0] m_tag   [SETS][WAYS];
    logic [AW-1:0] m_tgt   [SETS][WAYS];
    logic [1:0]    m_ctr   [SETS][WAYS];
    int            m_ptr   [SETS];

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_ctr[s][w]   = 2'b00;
            end
        end
    endtask

    function automatic exp_t m_lookup(input logic [AW-1:0] pc);
        exp_t          e;
        int            s;
        logic [TW-1:0] t;
        e = '0;
        s = int'(pc[2 +: IDX_W]);
        t = pc[2+IDX_W +: TW];
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                e.hit  = 1'b1;
                e.jump = m_jump[s][w];
                e.pred = m_jump[s][w] | m_ctr[s][w][1];
                e.tgt  = m_tgt[s][w];
                return e;
            end
        end
        return e;
    endfunction

    task automatic m_update(input logic uv, input logic [AW-1:0] upc, input logic uj,
                            input logic ut, input logic [AW-1:0] utg, input logic fl);
        int            s, w;
        logic [TW-1:0] t;
        bit            tk;
        if (fl) begin
            for (int i = 0; i < SETS; i++) begin
                m_ptr[i] = 0;
                for (int j = 0; j < WAYS; j++) m_valid[i][j] = 0;
            end
            return;
        end
        if (!uv) return;
        s  = int'(upc[2 +: IDX_W]);
        t  = upc[2+IDX_W +: TW];
        tk = ut | uj;
        w  = -1;
        for (int j = 0; j < WAYS; j++)
            if (w < 0 && m_valid[s][j] && m_tag[s][j] == t) w = j;
        if (w >= 0) begin
            m_tgt[s][w]  = utg;
            m_jump[s][w] = uj;
            if (tk && m_ctr[s][w] != 2'b11) m_ctr[s][w] = m_ctr[s][w] + 2'd1;
            if (!tk && m_ctr[s][w] != 2'b00) m_ctr[s][w] = m_ctr[s][w] - 2'd1;
        end else if (tk) begin
            for (int j = 0; j < WAYS; j++)
                if (w < 0 && !m_valid[s][j]) w = j;
            if (w < 0) begin
                w = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][w] = 1;
            m_tag[s][w]   = t;
            m_tgt[s][w]   = utg;
            m_jump[s][w]  = uj;
            m_ctr[s][w]   = uj ? 2'b11 : 2'b10;
        end
    endtask

    function automatic exp_t E(input logic h, input logic j, input logic p, input logic [AW-1:0] t);
        exp_t e;
        e.hit = h; e.jump = j; e.pred = p; e.tgt = t;
        return e;
    endfunction

    localparam exp_t MISS = '0;

    // One cycle: drive lookup/update, queue the expected lookup, compare mid-cycle,
    // then advance the model on the edge.
    task automatic cyc(input string name, input logic [AW-1:0] pc, input logic uv,
                       input logic [AW-1:0] upc, input logic uj, input logic ut,
                       input logic [AW-1:0] utg, input logic fl,
                       input bit use_model, input exp_t lit);
        exp_t e;
        pc_in          = pc;
        upd_valid_in   = uv;
        upd_pc_in      = upc;
        upd_is_jump_in = uj;
        upd_taken_in   = ut;
        upd_target_in  = utg;
        flush_in       = fl;
        sb_q.push_back(use_model ? m_lookup(pc) : lit);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({name, ".hit"},  is_branch_out,  e.hit);
        chk({name, ".jump"}, is_jump_out,    e.jump);
        chk({name, ".pred"}, pred_taken_out, e.pred);
        chk({name, ".tgt"},  target_out,     e.tgt);
        @(posedge clk);
        m_update(uv, upc, uj, ut, utg, fl);
        #1;
        upd_valid_in = 1'b0;
        flush_in     = 1'b0;
    endtask

    task automatic lk(input string name, input logic [AW-1:0] pc, input exp_t lit);
        cyc(name, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, lit);
    endtask

    task automatic up(input string name, input logic [AW-1:0] pc, input logic [AW-1:0] upc,
                      input logic uj, input logic ut, input logic [AW-1:0] utg, input exp_t lit);
        cyc(name, pc, 1'b1, upc, uj, ut, utg, 1'b0, 1'b0, lit);
    endtask

    initial begin
        logic [AW-1:0] a, b;
        rst            = 1'b1;
        pc_in          = 32'h0000_1000;
        upd_valid_in   = 1'b0;
        upd_pc_in      = '0;
        upd_is_jump_in = 1'b0;
        upd_taken_in   = 1'b0;
        upd_target_in  = '0;
        flush_in       = 1'b0;
        m_reset();
        #3;
        chk("reset.hit",  is_branch_out,  1'b0);
        chk("reset.pred", pred_taken_out, 1'b0);
        chk("reset.tgt",  target_out,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Allocation and 2-bit counter walk.
        up("alloc",  32'h1000, 32'h1000, 1'b0, 1'b1, 32'h2000, MISS);
        up("nt1",    32'h1000, 32'h1000, 1'b0, 1'b0, 32'h2000, E(1, 0, 1, 32'h2000));
        up("nt2",    32'h1000, 32'h1000, 1'b0, 1'b0, 32'h2000, E(1, 0, 0, 32'h2000));
        up("nt3",    32'h1000, 32'h1000, 1'b0, 1'b0, 32'h2000, E(1, 0, 0, 32'h2000));
        lk("sat0",   32'h1000, E(1, 0, 0, 32'h2000));
        // Same-cycle lookup sees old target; ctr 00 -> 01 so still not taken.
        up("samecyc", 32'h1000, 32'h1000, 1'b0, 1'b1, 32'h3000, E(1, 0, 0, 32'h2000));
        lk("newtgt", 32'h1000, E(1, 0, 0, 32'h3000));

        // Jump (taken forced), then flush racing an update.
        up("jalloc", 32'h1000, 32'h4000, 1'b1, 1'b0, 32'h5000, E(1, 0, 0, 32'h3000));
        lk("jump",   32'h4000, E(1, 1, 1, 32'h5000));
        cyc("flush_same", 32'h4000, 1'b1, 32'h6000, 1'b0, 1'b1, 32'h7000, 1'b1, 1'b0,
            E(1, 1, 1, 32'h5000));
        lk("fl_4000", 32'h4000, MISS);
        lk("fl_6000", 32'h6000, MISS);
        lk("fl_1000", 32'h1000, MISS);

        // Five aliases of set 0: ways 0..3 fill, fifth evicts way 0.
        for (int k = 0; k < 5; k++) begin
            a = AW'(k * SETS * 4);
            up($sformatf("alias_alloc%0d", k), a, a, 1'b0, 1'b1, 32'h8000 + AW'(k * 4), MISS);
        end
        for (int k = 0; k < 5; k++) begin
            a = AW'(k * SETS * 4);
            lk($sformatf("alias_lk%0d", k), a, (k == 0) ? MISS : E(1, 0, 1, 32'h8000 + AW'(k * 4)));
        end
        // Pointer now 1: sixth alias replaces way 1 (k=1), k=4 in way 0 survives.
        a = AW'(5 * SETS * 4);
        up("alias_alloc5", a, a, 1'b0, 1'b1, 32'h8014, MISS);
        lk("alias_k1_gone", AW'(1 * SETS * 4), MISS);
        lk("alias_k5", a, E(1, 0, 1, 32'h8014));
        lk("alias_k4", AW'(4 * SETS * 4), E(1, 0, 1, 32'h8010));
        lk("alias_k2", AW'(2 * SETS * 4), E(1, 0, 1, 32'h8008));
        // Not-taken miss must not allocate or disturb the set.
        a = AW'(6 * SETS * 4);
        up("nt_noalloc", a, a, 1'b0, 1'b0, 32'h9000, MISS);
        lk("nt_k6", a, MISS);
        lk("nt_k3", AW'(3 * SETS * 4), E(1, 0, 1, 32'h800C));

        // Randomised traffic over two heavily aliased sets, checked against the model.
        cyc("rnd_flush", 32'h0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, MISS);
        for (int i = 0; i < 400; i++) begin
            a = AW'(($urandom_range(0, 5) << (2 + IDX_W)) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
            b = AW'(($urandom_range(0, 5) << (2 + IDX_W)) | ($urandom_range(0, 1) << 2));
            cyc($sformatf("rnd%0d", i), ($urandom_range(0, 1) == 1) ? a : b,
                1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 49) == 0),
                1'b1, MISS);
        end

        // Asynchronous reset mid-cycle must kill hits without a clock edge.
        up("pre_rst_alloc", 32'h1000, 32'h1000, 1'b0, 1'b1, 32'hABC0, MISS);
        pc_in = 32'h1000;
        #2;
        chk("pre_rst.hit", is_branch_out, 1'b1);
        chk("pre_rst.tgt", target_out, 32'hABC0);
        rst = 1'b1;
        #1;
        chk("async_rst.hit",  is_branch_out,  1'b0);
        chk("async_rst.jump", is_jump_out,    1'b0);
        chk("async_rst.pred", pred_taken_out, 1'b0);
        chk("async_rst.tgt",  target_out,     32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lk("post_rst_1000", 32'h1000, MISS);
        lk("post_rst_k4",   AW'(4 * SETS * 4), MISS);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
